uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  RS232 receiver that sits directly upstream of the PSDRAM controller: it deserialises
//  the 8N1 serial line and presents each byte on ReceivedData with a 1-cycle ValidData strobe.
//  The controller uses that strobe to start a UART_WRITE transaction.
//  ReceivedData is held stable until the next good frame, so the controller may latch it
//  any number of cycles after the strobe.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        115200      line rate
//  OVERSAMPLE  16          ticks per bit (even, >=8)
//  TICK_DIV    CLK_HZ/(BAUD*OVERSAMPLE) rounded to nearest integer (27 at defaults); derived localparam
// PORTS
//  clk           in   1  system clock, 50 MHz, all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  RxD           in   1  serial input, asynchronous, idle high
//  ValidData     out  1  1-cycle pulse: new good byte on ReceivedData
//  ReceivedData  out  8  last good byte, LSB first on the line
//  FrameError    out  1  1-cycle pulse: stop bit sampled low
//  RxBusy        out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset values: ValidData=0, ReceivedData=8'h00, FrameError=0, RxBusy=0.
//    Synchroniser flops reset to 1; FSM resets to IDLE.
//  - RxD passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
//  - Tick generator: counter 0..TICK_DIV-1 emits a 1-cycle tick at wrap.
//    It is cleared on start detect so bit sampling is phase-aligned to the falling edge.
//  - Bit sampling: a 4-bit tick count runs within each bit.
//    The bit value is the majority of rxs at ticks 7, 8 and 9.
//    The bit is decided at tick 9; the bit ends at tick 15.
//  - FSM:
//    IDLE  : rxs 1->0 edge -> START; RxBusy<=1.
//    START : majority at mid-bit = 1 -> IDLE (glitch; no output).
//            Else at end of bit -> DATA, bit index 0.
//    DATA  : shift decided bit into shift-register MSB (LSB-first on line).
//            After bit 7 completes -> STOP.
//    STOP  : at decision tick, majority 1 -> ReceivedData<=shift, ValidData<=1 next cycle,
//            then IDLE immediately (does not wait for end of stop bit, so back-to-back
//            frames are caught). Majority 0 -> FrameError<=1, ReceivedData unchanged -> BREAK.
//    BREAK : wait until rxs has been 1 for OVERSAMPLE consecutive ticks -> IDLE.
//            A held-low line yields exactly one FrameError.
//  - RxBusy=0 only in IDLE.
//  - Latency: ValidData rises exactly 1 clk after the stop-bit decision tick, i.e.
//    about 9.56 bit-times after the start edge (+2 clk synchroniser).
//  - ValidData and FrameError are never high in the same cycle; each is high for
//    exactly 1 clk per frame.
//  - The minimum byte spacing (about 4340 clk at defaults) far exceeds the 8-clk
//    PSDRAM write cycle, so no buffering or back-pressure is needed.
//  - rst asserted mid-frame: next cycle FSM=IDLE and all counters=0.
//    ReceivedData is reset to 0. No ValidData or FrameError pulse for the aborted frame.
//  - Baud tolerance: correct reception for a transmitter off by up to +/-3 %.
// STRUCTURE
//  - uart_defs.vh (shared include):
//    FSM state encodings RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK;
//    default CLK_HZ/BAUD; TICK_DIV rounding macro.
//    A future uart_tx block reuses this file.
//  - Sub-module uart_baud_tick (params DIV; ports clk, rst, clr, tick) holds the divider.
//  - FSM, bit/tick counters, majority vote and synchroniser stay in this module.
// TESTING
//  1 rst held 3 clk with RxD=0 -> all outputs 0, RxBusy=0; release with RxD=1
//    -> stays IDLE, no pulses.
//  2 Send 8'hA5 at 115200 -> exactly one ValidData pulse, 1 clk wide, ReceivedData=8'hA5.
//    ReceivedData still 8'hA5 10000 clk later.
//  3 Back-to-back 8'h00 then 8'hFF with no idle gap -> two ValidData pulses,
//    values 00 then FF, no FrameError.
//  4 RxD low glitch of 5 ticks (135 clk) -> RxBusy pulses high then low.
//    No ValidData, ReceivedData unchanged.
//  5 Frame 8'h3C with stop bit 0, line held low 3 bit-times, then idle, then good 8'h5A
//    -> one FrameError, ReceivedData unchanged; then ValidData with 8'h5A.
//  6 rst asserted at data bit 4 of 8'hC3, released, then 8'h81 sent -> no pulse for 8'hC3.
//    ValidData with 8'h81. Repeat 8'h81 at BAUD*1.03 and BAUD*0.97 -> correct byte.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// uart_rx_byte_pkg: shared UART receiver state encodings, default line settings and divider rounding.
package uart_rx_byte_pkg;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
    localparam int DEF_CLK_HZ = 50_000_000;
    localparam int DEF_BAUD = 115200;
    function automatic int tick_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a 1-cycle tick every DIV clocks, restartable by clr.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = !clr && cnt_q == W'(DIV - 1);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 oversampling UART receiver with majority-vote bit decisions and break handling.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD = DEF_BAUD,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       ValidData,
    output logic [7:0] ReceivedData,
    output logic       FrameError,
    output logic       RxBusy
);
    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1 = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    rx_state_e state_q, state_d;
    logic s1_q, rxs_q, rxs_prev_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [1:0] smp_q, smp_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    logic tick, start_det, maj, dec, bend, stop_dec;

    assign start_det = state_q == RX_IDLE && rxs_prev_q && !rxs_q;
    assign maj = (smp_q[0] & smp_q[1]) | (rxs_q & (smp_q[0] | smp_q[1]));
    assign dec = tick && tcnt_q == T_DEC;
    assign bend = tick && tcnt_q == T_END;
    assign stop_dec = state_q == RX_STOP && dec;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (start_det),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            tcnt_q     <= '0;
            bidx_q     <= '0;
            smp_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            s1_q       <= RxD;
            rxs_q      <= s1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bidx_q     <= bidx_d;
            smp_q      <= smp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  state_d = start_det ? RX_START : RX_IDLE;
            RX_START: state_d = (dec && maj) ? RX_IDLE : bend ? RX_DATA : RX_START;
            RX_DATA:  state_d = (bend && bidx_q == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:  state_d = dec ? (maj ? RX_IDLE : RX_BREAK) : RX_STOP;
            RX_BREAK: state_d = (tick && rxs_q && tcnt_q == T_END) ? RX_IDLE : RX_BREAK;
            default:  state_d = RX_IDLE;
        endcase
    end

    // In BREAK the tick counter instead counts consecutive high ticks.
    always_comb begin
        tcnt_d = (start_det || stop_dec) ? '0 :
                 !tick ? tcnt_q :
                 (state_q == RX_BREAK && !rxs_q) ? '0 :
                 (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
        bidx_d = state_q == RX_START ? '0 : (state_q == RX_DATA && bend) ? bidx_q + 3'd1 : bidx_q;
        smp_d = (tick && (tcnt_q == T_S0 || tcnt_q == T_S1)) ? {smp_q[0], rxs_q} : smp_q;
        shift_d = (state_q == RX_DATA && dec) ? {maj, shift_q[7:1]} : shift_q;
        valid_d = stop_dec && maj;
        ferr_d = stop_dec && !maj;
        data_d = valid_d ? shift_q : data_q;
    end

    always_comb begin
        ValidData = valid_q;
        ReceivedData = data_q;
        FrameError = ferr_q;
        RxBusy = state_q != RX_IDLE;
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: table-driven frames plus corner sequences, scoreboarded received bytes.
module tb_uart_rx_byte;
    localparam int BCLK = 432;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RxD = 1'b0;
    logic ValidData, FrameError, RxBusy;
    logic [7:0] ReceivedData;

    int total = 0;
    int bad = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    logic prev_v = 1'b0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bclk;
        int         idle;
        int         dv_inc;
        int         fe_inc;
        logic [7:0] rd;
    } vec_t;
    vec_t vecs[7];

    uart_rx_byte dut (
        .clk         (clk),
        .rst         (rst),
        .RxD         (RxD),
        .ValidData   (ValidData),
        .ReceivedData(ReceivedData),
        .FrameError  (FrameError),
        .RxBusy      (RxBusy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ValidData) begin
                dv_cnt++;
                check("dv_width", {31'd0, prev_v}, 0);
                if (sb_q.size() == 0) check("sb_unexpected_dv", 1, 0);
                else check("sb_data", {24'd0, ReceivedData}, {24'd0, sb_q.pop_front()});
            end
            if (FrameError) fe_cnt++;
            if (ValidData || FrameError) check("dv_fe_excl", {31'd0, ValidData & FrameError}, 0);
        end
        prev_v <= ValidData;
    end

    task automatic idle(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk, input bit push);
        if (push && stop) sb_q.push_back(b);
        RxD = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (bclk) @(negedge clk);
        end
        RxD = stop;
        repeat (bclk) @(negedge clk);
    endtask

    initial begin
        int dv0, fe0;
        bit seen;
        vecs[0] = '{8'hA5, 1'b1, BCLK, 10000, 1, 0, 8'hA5};
        vecs[1] = '{8'h5A, 1'b1, BCLK, 2 * BCLK, 1, 0, 8'h5A};
        vecs[2] = '{8'h81, 1'b1, 419, 2 * BCLK, 1, 0, 8'h81};
        vecs[3] = '{8'hC3, 1'b1, 445, 2 * BCLK, 1, 0, 8'hC3};
        vecs[4] = '{8'h3C, 1'b0, BCLK, 2 * BCLK, 0, 1, 8'hC3};
        vecs[5] = '{8'h7E, 1'b1, 419, 2 * BCLK, 1, 0, 8'h7E};
        vecs[6] = '{8'h01, 1'b1, 445, 2 * BCLK, 1, 0, 8'h01};

        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, ValidData}, 0);
        check("rst_data", {24'd0, ReceivedData}, 0);
        check("rst_ferr", {31'd0, FrameError}, 0);
        check("rst_busy", {31'd0, RxBusy}, 0);
        RxD = 1'b1;
        rst = 1'b0;
        idle(500);
        check("idle_busy", {31'd0, RxBusy}, 0);
        check("idle_pulses", dv_cnt + fe_cnt, 0);

        for (int v = 0; v < 7; v++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].bclk, 1'b1);
            idle(vecs[v].idle);
            check($sformatf("vec%0d_data", v), {24'd0, ReceivedData}, {24'd0, vecs[v].rd});
            check($sformatf("vec%0d_dv", v), dv_cnt - dv0, vecs[v].dv_inc);
            check($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].fe_inc);
            check($sformatf("vec%0d_busy", v), {31'd0, RxBusy}, 0);
        end

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b1, BCLK, 1'b1);
        send_frame(8'hFF, 1'b1, BCLK, 1'b1);
        idle(2 * BCLK);
        check("b2b_dv", dv_cnt - dv0, 2);
        check("b2b_fe", fe_cnt - fe0, 0);
        check("b2b_data", {24'd0, ReceivedData}, 32'hFF);

        dv0 = dv_cnt;
        seen = 0;
        RxD = 1'b0;
        for (int i = 0; i < 135; i++) begin
            @(negedge clk);
            seen |= RxBusy;
        end
        RxD = 1'b1;
        for (int i = 0; i < 1000 && RxBusy; i++) @(negedge clk);
        check("glitch_busy_hi", {31'd0, seen}, 1);
        check("glitch_busy_lo", {31'd0, RxBusy}, 0);
        idle(2 * BCLK);
        check("glitch_dv", dv_cnt - dv0, 0);
        check("glitch_data", {24'd0, ReceivedData}, 32'hFF);

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, BCLK, 1'b1);
        repeat (3 * BCLK) @(negedge clk);
        idle(2 * BCLK);
        check("brk_fe", fe_cnt - fe0, 1);
        check("brk_dv", dv_cnt - dv0, 0);
        check("brk_data", {24'd0, ReceivedData}, 32'hFF);
        check("brk_busy", {31'd0, RxBusy}, 0);
        send_frame(8'h5A, 1'b1, BCLK, 1'b1);
        idle(2 * BCLK);
        check("brk_next_data", {24'd0, ReceivedData}, 32'h5A);
        check("brk_next_dv", dv_cnt - dv0, 1);

        dv0 = dv_cnt;
        fe0 = fe_cnt;
        RxD = 1'b0;
        repeat (BCLK) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            RxD = (i == 0 || i == 1);
            repeat (i == 4 ? BCLK / 2 : BCLK) @(negedge clk);
        end
        check("abort_busy_pre", {31'd0, RxBusy}, 1);
        rst = 1'b1;
        RxD = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, RxBusy}, 0);
        check("abort_data", {24'd0, ReceivedData}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1000);
        check("abort_dv", dv_cnt - dv0, 0);
        check("abort_fe", fe_cnt - fe0, 0);
        send_frame(8'h81, 1'b1, BCLK, 1'b1);
        idle(2 * BCLK);
        check("abort_next_data", {24'd0, ReceivedData}, 32'h81);
        check("abort_next_dv", dv_cnt - dv0, 1);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
